mult4_arb: RTL

- Round-robin arbiter and sequencer that shares one `mult4` 4x4 array multiplier among NREQ requesters.
- Each requester presents operands with a valid/ready handshake.
- The block grants one requester, registers its operands into the shared `mult4`, and waits a fixed number of settle cycles to cover the gate delays.
- It then registers the 8-bit product and holds it, tagged with the requester id, until the consumer accepts it.

---
 rtl/mult4_arb_pkg.sv | 6 +
 rtl/mult4_arb_if.sv | 10 +
 rtl/mult4.sv | 11 +
 rtl/mult4_arb_rr_pick.sv | 19 +
 rtl/mult4_arb.sv | 70 +++++++
 5 files changed

// File: rtl/mult4_arb_pkg.sv
// mult4_arb_pkg: state encodings and shared constants for the mult4 arbiter
package mult4_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_HOLD = 2'd2} state_t;
  localparam int SETTLE_CYC_DEF = 2;
  localparam int OP_CNT_W = 16;
endpackage

// File: rtl/mult4_arb_if.sv
// mult4_arb_if: requester operand handshake and result handshake of the shared multiplier
interface mult4_arb_if #(parameter int NREQ = 4, parameter int ID_W = 2);
  logic [NREQ-1:0] req_valid, req_ready;
  logic [4*NREQ-1:0] req_a, req_b;
  logic res_valid, res_ready;
  logic [7:0] res_data;
  logic [ID_W-1:0] res_id;
  modport master (output req_valid, req_a, req_b, res_ready, input req_ready, res_valid, res_data, res_id);
  modport slave (input req_valid, req_a, req_b, res_ready, output req_ready, res_valid, res_data, res_id);
endinterface

// File: rtl/mult4.sv
// mult4: 4x4 unsigned array multiplier summing shifted partial-product rows
module mult4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) p = p + ({4'd0, a & {4{b[i]}}} << i);
  end
endmodule

// File: rtl/mult4_arb_rr_pick.sv
// mult4_arb_rr_pick: one-hot round-robin pick of the first valid at or above ptr, with wrap
module mult4_arb_rr_pick #(parameter int NREQ = 4, parameter int ID_W = 2) (
  input  logic [ID_W-1:0] ptr,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] index
);
  logic [2*NREQ-1:0] dv, gr;
  logic [NREQ-1:0] hit;
  always_comb begin
    dv = {valid, valid} >> ptr;
    hit = '0;
    for (int k = NREQ - 1; k >= 0; k--) hit = dv[k] ? NREQ'(1) << k : hit;
    gr = {hit, hit} << ptr;
    grant = gr[2*NREQ-1:NREQ];
    index = '0;
    for (int i = 0; i < NREQ; i++) index = grant[i] ? ID_W'(i) : index;
  end
endmodule

// File: rtl/mult4_arb.sv
// mult4_arb: round-robin sequencer sharing one mult4 among NREQ requesters
module mult4_arb import mult4_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int ID_W = 2,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  mult4_arb_if.slave          bus,
  output logic                busy,
  output logic [OP_CNT_W-1:0] op_cnt
);
  localparam int CNT_W = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  state_t state;
  logic [ID_W-1:0] rr_ptr, id_reg, g_idx;
  logic [CNT_W-1:0] cnt;
  logic [3:0] a_reg, b_reg, a_sel, b_sel;
  logic [7:0] prod;
  logic [NREQ-1:0] grant;
  mult4_arb_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (.ptr(rr_ptr), .valid(bus.req_valid), .grant(grant), .index(g_idx));
  mult4 u_mult (.a(a_reg), .b(b_reg), .p(prod));
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel = grant[i] ? bus.req_a[4*i +: 4] : a_sel;
      b_sel = grant[i] ? bus.req_b[4*i +: 4] : b_sel;
    end
  end
  // grant is masked during reset so requesters never see a strobe that cannot transfer
  assign bus.req_ready = (rst_n && state == ST_IDLE) ? grant : '0;
  assign busy = state == ST_CALC || state == ST_HOLD;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      a_reg <= '0;
      b_reg <= '0;
      id_reg <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data <= '0;
      bus.res_id <= '0;
      op_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|grant) begin
          a_reg <= a_sel;
          b_reg <= b_sel;
          id_reg <= g_idx;
          rr_ptr <= (g_idx == ID_W'(NREQ - 1)) ? '0 : g_idx + 1'b1;
          cnt <= CNT_W'(SETTLE_CYC - 1);
          state <= ST_CALC;
        end
        ST_CALC: if (cnt == '0) begin
          bus.res_data <= prod;
          bus.res_id <= id_reg;
          bus.res_valid <= 1'b1;
          state <= ST_HOLD;
        end else cnt <= cnt - 1'b1;
        ST_HOLD: if (bus.res_ready) begin
          bus.res_valid <= 1'b0;
          op_cnt <= op_cnt + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
